// File: rtl/swd_target_responder_if.sv
// SWD pad-side signals between the host sequencer (master) and the target responder (slave).
interface swd_target_responder_if;
  logic SWCLK_I;
  logic SWDIO_I;
  logic SWDIO_O;
  logic SWDIO_T;

  modport master (output SWCLK_I, output SWDIO_I, input SWDIO_O, input SWDIO_T);
  modport slave  (input SWCLK_I, input SWDIO_I, output SWDIO_O, output SWDIO_T);
endinterface

// File: rtl/swd_target_responder.sv
// SWD target (DP responder): oversamples SWCLK/SWDIO on clk, decodes requests, returns ACK and
// serves a small DP/AP register file. Loopback target for the host sequencer.
module swd_target_responder #(
  parameter logic [31:0] IDCODE      = 32'h2BA01477,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned RESET_ONES  = 50
) (
  input  logic                         clk,
  input  logic                         resetn,
  swd_target_responder_if.slave        swd,
  input  logic [2:0]                   ack_sel,
  output logic                         evt_valid,
  output logic                         evt_apndp,
  output logic                         evt_rnw,
  output logic [1:0]                   evt_addr,
  output logic [31:0]                  evt_wdata,
  output logic [1:0]                   evt_err,
  output logic                         locked_out
);

  localparam logic [5:0] TurnLast  = 6'(TURN_CYCLES - 1);
  localparam logic [5:0] ResetOnes = 6'(RESET_ONES);

  typedef enum logic [3:0] {
    StLockout, StLrst, StIdle, StReq, StTrn1, StAck, StRdata, StTrn2, StTrn2w, StWdata
  } state_e;

  state_e      state_q;
  logic [2:0]  sclk_sync_q;
  logic [1:0]  sdio_sync_q;
  logic [5:0]  cnt_q;
  logic [5:0]  ones_q;
  logic [5:0]  ones_d;
  logic [5:0]  req_q;
  logic [2:0]  ack_q;
  logic [31:0] rsr_q;
  logic        rpar_q;
  logic [31:0] wsr_q;
  logic        dio_o_q;
  logic        dio_t_q;
  logic [31:0] dp_q [4];
  logic [31:0] ap_q [4];

  logic        sck_rise;
  logic        sbit;
  logic        line_rst;
  logic        req_ok;
  logic [1:0]  addr;
  logic [31:0] rd_val;

  // SWCLK and SWDIO share the same 2-FF delay so the sampled bit lines up with the detected edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_sync_q <= '0;
      sdio_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], swd.SWCLK_I};
      sdio_sync_q <= {sdio_sync_q[0], swd.SWDIO_I};
    end
  end

  assign sck_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sbit     = sdio_sync_q[1];
  assign addr     = req_q[3:2];

  always_comb begin
    ones_d = '0;
    if (sbit) ones_d = (ones_q == 6'h3f) ? ones_q : ones_q + 6'd1;
  end

  assign line_rst = (ones_d >= ResetOnes);
  // Evaluated on the park edge: req_q holds APnDP..stop, sbit is park.
  assign req_ok   = (req_q[4] == ^req_q[3:0]) && !req_q[5] && sbit;

  always_comb begin
    rd_val = ap_q[addr];
    if (!req_q[0]) rd_val = (addr == 2'd0) ? IDCODE : dp_q[addr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StLockout;
      cnt_q      <= '0;
      ones_q     <= '0;
      req_q      <= '0;
      ack_q      <= '0;
      rsr_q      <= '0;
      rpar_q     <= 1'b0;
      wsr_q      <= '0;
      dio_o_q    <= 1'b0;
      dio_t_q    <= 1'b1;
      locked_out <= 1'b1;
      evt_valid  <= 1'b0;
      evt_apndp  <= 1'b0;
      evt_rnw    <= 1'b0;
      evt_addr   <= '0;
      evt_wdata  <= '0;
      evt_err    <= '0;
      for (int i = 0; i < 4; i++) begin
        dp_q[i] <= '0;
        ap_q[i] <= '0;
      end
    end else begin
      evt_valid <= 1'b0;
      if (sck_rise) begin
        ones_q <= ones_d;
        if (line_rst) begin
          state_q <= StLrst;
          cnt_q   <= '0;
          dio_t_q <= 1'b1;
          dio_o_q <= 1'b0;
        end else begin
          unique case (state_q)
            StLockout: ;
            StLrst: begin
              if (!sbit) begin
                state_q    <= StIdle;
                locked_out <= 1'b0;
              end
            end
            StIdle: begin
              if (sbit) begin
                state_q <= StReq;
                cnt_q   <= '0;
              end
            end
            StReq: begin
              if (cnt_q == 6'd6) begin
                cnt_q <= '0;
                if (req_ok) begin
                  state_q <= StTrn1;
                  ack_q   <= ack_sel;
                end else begin
                  state_q    <= StLockout;
                  locked_out <= 1'b1;
                  evt_valid  <= 1'b1;
                  evt_apndp  <= req_q[0];
                  evt_rnw    <= req_q[1];
                  evt_addr   <= req_q[3:2];
                  evt_wdata  <= '0;
                  evt_err    <= 2'd1;
                end
              end else begin
                req_q <= {sbit, req_q[5:1]};
                cnt_q <= cnt_q + 6'd1;
              end
            end
            StTrn1: begin
              if (cnt_q == TurnLast) begin
                state_q <= StAck;
                cnt_q   <= '0;
                dio_t_q <= 1'b0;
                dio_o_q <= ack_q[0];
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
            StAck: begin
              if (cnt_q != 6'd2) begin
                dio_o_q <= (cnt_q == 6'd0) ? ack_q[1] : ack_q[2];
                cnt_q   <= cnt_q + 6'd1;
              end else begin
                cnt_q <= '0;
                if (ack_q == 3'b001 && req_q[1]) begin
                  state_q <= StRdata;
                  rsr_q   <= {1'b0, rd_val[31:1]};
                  rpar_q  <= ^rd_val;
                  dio_o_q <= rd_val[0];
                end else begin
                  state_q <= (ack_q == 3'b001) ? StTrn2w : StTrn2;
                  dio_t_q <= 1'b1;
                  dio_o_q <= 1'b0;
                end
              end
            end
            StRdata: begin
              if (cnt_q == 6'd32) begin
                state_q <= StTrn2;
                cnt_q   <= '0;
                dio_t_q <= 1'b1;
                dio_o_q <= 1'b0;
              end else begin
                dio_o_q <= (cnt_q == 6'd31) ? rpar_q : rsr_q[0];
                rsr_q   <= {1'b0, rsr_q[31:1]};
                cnt_q   <= cnt_q + 6'd1;
              end
            end
            StTrn2: begin
              if (cnt_q == TurnLast) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                evt_valid <= 1'b1;
                evt_apndp <= req_q[0];
                evt_rnw   <= req_q[1];
                evt_addr  <= req_q[3:2];
                evt_wdata <= '0;
                evt_err   <= 2'd0;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
            StTrn2w: begin
              if (cnt_q == TurnLast) begin
                state_q <= StWdata;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
            StWdata: begin
              if (cnt_q == 6'd32) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                evt_valid <= 1'b1;
                evt_apndp <= req_q[0];
                evt_rnw   <= req_q[1];
                evt_addr  <= req_q[3:2];
                evt_wdata <= wsr_q;
                evt_err   <= (sbit == ^wsr_q) ? 2'd0 : 2'd2;
                // DP A=0 is ABORT: event only, nothing stored.
                if (sbit == ^wsr_q) begin
                  if (req_q[0])              ap_q[addr] <= wsr_q;
                  else if (addr != 2'd0)     dp_q[addr] <= wsr_q;
                end
              end else begin
                wsr_q <= {sbit, wsr_q[31:1]};
                cnt_q <= cnt_q + 6'd1;
              end
            end
            default: state_q <= StLockout;
          endcase
        end
      end
    end
  end

  assign swd.SWDIO_O = dio_o_q;
  assign swd.SWDIO_T = dio_t_q;

endmodule

// File: tb/tb_swd_target_responder.sv
// Self-checking bench: bit-level SWD host driving the responder, checked against a register model.
module tb_swd_target_responder;

  localparam logic [31:0] IDCODE = 32'h2BA01477;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  ack_sel = 3'b001;
  logic        evt_valid;
  logic        evt_apndp;
  logic        evt_rnw;
  logic [1:0]  evt_addr;
  logic [31:0] evt_wdata;
  logic [1:0]  evt_err;
  logic        locked_out;

  swd_target_responder_if swd_if();

  swd_target_responder dut (
    .clk        (clk),
    .resetn     (resetn),
    .swd        (swd_if),
    .ack_sel    (ack_sel),
    .evt_valid  (evt_valid),
    .evt_apndp  (evt_apndp),
    .evt_rnw    (evt_rnw),
    .evt_addr   (evt_addr),
    .evt_wdata  (evt_wdata),
    .evt_err    (evt_err),
    .locked_out (locked_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int evt_seen = 0;
  logic [31:0] dp_m [4];
  logic [31:0] ap_m [4];

  always @(posedge clk) if (evt_valid === 1'b1) evt_seen++;

  // One SWCLK period; returns the pad state seen just before the rising edge.
  task automatic swd_edge(input logic din, output logic so, output logic st);
    swd_if.SWDIO_I = din;
    swd_if.SWCLK_I = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    so = swd_if.SWDIO_O;
    st = swd_if.SWDIO_T;
    swd_if.SWCLK_I = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mk_req(input logic apndp, input logic rnw, input logic [1:0] a);
    return {1'b1, 1'b0, apndp ^ rnw ^ a[0] ^ a[1], a[1], a[0], rnw, apndp, 1'b1};
  endfunction

  task automatic send_req(input logic [7:0] req);
    logic o, t;
    for (int i = 0; i < 2; i++) swd_edge(1'b0, o, t);
    for (int i = 0; i < 8; i++) swd_edge(req[i], o, t);
  endtask

  task automatic line_reset();
    logic o, t;
    for (int i = 0; i < 60; i++) swd_edge(1'b1, o, t);
    for (int i = 0; i < 2; i++) swd_edge(1'b0, o, t);
  endtask

  // Full transaction as a host would run it; drv counts samples where the target drove the pad.
  task automatic swd_txn(input logic [7:0] req, input logic [31:0] wdata, input logic wpar,
                         output logic [2:0] ack, output logic [31:0] rdata, output logic rpar,
                         output int drv);
    logic o, t;
    drv = 0;
    rdata = '0;
    rpar = 1'b0;
    send_req(req);
    swd_edge(1'b0, o, t); drv += int'(!t);
    for (int i = 0; i < 3; i++) begin
      swd_edge(1'b0, o, t); ack[i] = o; drv += int'(!t);
    end
    if (ack == 3'b001 && req[2]) begin
      for (int i = 0; i < 32; i++) begin
        swd_edge(1'b0, o, t); rdata[i] = o; drv += int'(!t);
      end
      swd_edge(1'b0, o, t); rpar = o; drv += int'(!t);
      for (int i = 0; i < 2; i++) begin
        swd_edge(1'b0, o, t); drv += int'(!t);
      end
    end else if (ack == 3'b001) begin
      swd_edge(1'b0, o, t); drv += int'(!t);
      for (int i = 0; i < 32; i++) begin
        swd_edge(wdata[i], o, t); drv += int'(!t);
      end
      swd_edge(wpar, o, t); drv += int'(!t);
      swd_edge(1'b0, o, t); drv += int'(!t);
    end else begin
      for (int i = 0; i < 4; i++) begin
        swd_edge(1'b0, o, t); drv += int'(!t);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({swd_if.SWDIO_T, swd_if.SWDIO_O, locked_out} !== 3'b101) begin
      errors++;
      $display("FAIL reset_pins: got T/O/lock=%b want 101",
               {swd_if.SWDIO_T, swd_if.SWDIO_O, locked_out});
    end
    checks++;
    if ({evt_valid, evt_apndp, evt_rnw, evt_addr, evt_wdata, evt_err} !== 39'd0) begin
      errors++;
      $display("FAIL reset_evt: got %h want 0",
               {evt_valid, evt_apndp, evt_rnw, evt_addr, evt_wdata, evt_err});
    end
  endtask

  task automatic test_linereset_idcode();
    logic [2:0] ack; logic [31:0] rd; logic rp; int drv, e0;
    line_reset();
    checks++;
    if (locked_out !== 1'b0) begin
      errors++; $display("FAIL lrst_unlock: got %b want 0", locked_out);
    end
    ack_sel = 3'b001;
    e0 = evt_seen;
    swd_txn(mk_req(1'b0, 1'b1, 2'd0), 32'd0, 1'b0, ack, rd, rp, drv);
    checks++;
    if (ack !== 3'b001) begin errors++; $display("FAIL idcode_ack: got %b want 001", ack); end
    checks++;
    if (rd !== IDCODE) begin errors++; $display("FAIL idcode_data: got %h want %h", rd, IDCODE); end
    checks++;
    if (rp !== ^IDCODE) begin errors++; $display("FAIL idcode_par: got %b want %b", rp, ^IDCODE); end
    checks++;
    if (drv != 36) begin errors++; $display("FAIL idcode_drv: got %0d want 36", drv); end
    checks++;
    if (evt_seen - e0 != 1 || evt_rnw !== 1'b1 || evt_err !== 2'd0) begin
      errors++;
      $display("FAIL idcode_evt: got n=%0d rnw=%b err=%0d want 1 1 0", evt_seen - e0, evt_rnw, evt_err);
    end
  endtask

  task automatic test_write_read();
    logic [2:0] ack; logic [31:0] rd; logic rp; int drv;
    ack_sel = 3'b001;
    swd_txn(mk_req(1'b0, 1'b0, 2'd2), 32'hDEADBEEF, 1'b0, ack, rd, rp, drv);
    dp_m[2] = 32'hDEADBEEF;
    checks++;
    if ({ack, evt_rnw, evt_addr, evt_wdata, evt_err} !== {3'b001, 1'b0, 2'd2, 32'hDEADBEEF, 2'd0}) begin
      errors++;
      $display("FAIL wr_dp2: got ack=%b addr=%0d wd=%h err=%0d want 001 2 deadbeef 0",
               ack, evt_addr, evt_wdata, evt_err);
    end
    checks++;
    if (drv != 3) begin errors++; $display("FAIL wr_dp2_drv: got %0d want 3", drv); end
    swd_txn(mk_req(1'b0, 1'b1, 2'd2), 32'd0, 1'b0, ack, rd, rp, drv);
    checks++;
    if ({ack, rd, rp} !== {3'b001, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL rd_dp2: got ack=%b data=%h par=%b want 001 deadbeef 0", ack, rd, rp);
    end
    checks++;
    if ({evt_rnw, evt_wdata, evt_err} !== {1'b1, 32'd0, 2'd0}) begin
      errors++; $display("FAIL rd_dp2_evt: got rnw=%b wd=%h err=%0d", evt_rnw, evt_wdata, evt_err);
    end
  endtask

  task automatic test_wait();
    logic [2:0] ack; logic [31:0] rd; logic rp; int drv, e0;
    ack_sel = 3'b010;
    e0 = evt_seen;
    swd_txn(mk_req(1'b1, 1'b1, 2'd1), 32'd0, 1'b0, ack, rd, rp, drv);
    ack_sel = 3'b001;
    checks++;
    if (ack !== 3'b010) begin errors++; $display("FAIL wait_ack: got %b want 010", ack); end
    checks++;
    if (drv != 3 || swd_if.SWDIO_T !== 1'b1) begin
      errors++; $display("FAIL wait_release: got drv=%0d T=%b want 3 1", drv, swd_if.SWDIO_T);
    end
    checks++;
    if (evt_seen - e0 != 1 || {evt_apndp, evt_rnw, evt_addr, evt_err} !== {1'b1, 1'b1, 2'd1, 2'd0}) begin
      errors++; $display("FAIL wait_evt: got n=%0d ap=%b rnw=%b a=%0d err=%0d", evt_seen - e0,
                         evt_apndp, evt_rnw, evt_addr, evt_err);
    end
  endtask

  task automatic test_req_parity_err();
    logic [2:0] ack; logic [31:0] rd; logic rp; int drv, e0;
    logic o, t;
    int drv_bad;
    e0 = evt_seen;
    drv_bad = 0;
    send_req(8'hA5 ^ 8'h20);
    for (int i = 0; i < 6; i++) begin
      swd_edge(1'b0, o, t); drv_bad += int'(!t);
    end
    checks++;
    if (drv_bad != 0) begin errors++; $display("FAIL reqerr_drive: got %0d driven want 0", drv_bad); end
    checks++;
    if (evt_seen - e0 != 1 || evt_err !== 2'd1 || locked_out !== 1'b1) begin
      errors++; $display("FAIL reqerr_evt: got n=%0d err=%0d lock=%b want 1 1 1",
                         evt_seen - e0, evt_err, locked_out);
    end
    e0 = evt_seen;
    swd_txn(mk_req(1'b0, 1'b1, 2'd0), 32'd0, 1'b0, ack, rd, rp, drv);
    checks++;
    if (drv != 0 || evt_seen != e0 || locked_out !== 1'b1) begin
      errors++; $display("FAIL lockout_ignore: got drv=%0d n=%0d lock=%b want 0 0 1",
                         drv, evt_seen - e0, locked_out);
    end
  endtask

  task automatic test_wdata_parity_err();
    logic [2:0] ack; logic [31:0] rd; logic rp; int drv;
    line_reset();
    ack_sel = 3'b001;
    swd_txn(mk_req(1'b1, 1'b0, 2'd3), 32'h12345678, ^32'h12345678, ack, rd, rp, drv);
    ap_m[3] = 32'h12345678;
    swd_txn(mk_req(1'b1, 1'b0, 2'd3), 32'h00000001, 1'b0, ack, rd, rp, drv);
    checks++;
    if (evt_err !== 2'd2) begin errors++; $display("FAIL wpar_err: got %0d want 2", evt_err); end
    swd_txn(mk_req(1'b1, 1'b1, 2'd3), 32'd0, 1'b0, ack, rd, rp, drv);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL wpar_nowrite: got %h want 12345678", rd); end
  endtask

  task automatic test_random(input int n);
    logic [2:0]  ack_tab [6];
    logic [2:0]  ack, exp_ack;
    logic [31:0] rd, wd, exp_rd;
    logic [1:0]  a, exp_err;
    logic        apndp, rnw, good, rp;
    int          drv, e0, exp_drv;
    ack_tab = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b110};
    for (int k = 0; k < n; k++) begin
      apndp   = 1'($urandom);
      rnw     = 1'($urandom);
      a       = 2'($urandom);
      wd      = $urandom;
      good    = ($urandom_range(0, 5) != 0);
      exp_ack = ack_tab[$urandom_range(0, 5)];
      ack_sel = exp_ack;
      exp_rd  = apndp ? ap_m[a] : ((a == 2'd0) ? IDCODE : dp_m[a]);
      exp_drv = (exp_ack == 3'b001 && rnw) ? 36 : 3;
      exp_err = (exp_ack == 3'b001 && !rnw && !good) ? 2'd2 : 2'd0;
      e0 = evt_seen;
      swd_txn(mk_req(apndp, rnw, a), wd, (^wd) ^ !good, ack, rd, rp, drv);
      checks++;
      if (ack !== exp_ack || drv != exp_drv) begin
        errors++; $display("FAIL rnd_ack[%0d]: got ack=%b drv=%0d want %b %0d", k, ack, drv,
                           exp_ack, exp_drv);
      end
      if (exp_ack == 3'b001 && rnw) begin
        checks++;
        if ({rd, rp} !== {exp_rd, ^exp_rd}) begin
          errors++; $display("FAIL rnd_rdata[%0d]: got %h/%b want %h/%b", k, rd, rp, exp_rd, ^exp_rd);
        end
      end
      checks++;
      if (evt_seen - e0 != 1 ||
          {evt_apndp, evt_rnw, evt_addr, evt_wdata, evt_err} !==
          {apndp, rnw, a, (exp_ack == 3'b001 && !rnw) ? wd : 32'd0, exp_err}) begin
        errors++; $display("FAIL rnd_evt[%0d]: got n=%0d ap=%b rnw=%b a=%0d wd=%h err=%0d", k,
                           evt_seen - e0, evt_apndp, evt_rnw, evt_addr, evt_wdata, evt_err);
      end
      if (exp_ack == 3'b001 && !rnw && good) begin
        if (apndp) ap_m[a] = wd;
        else if (a != 2'd0) dp_m[a] = wd;
      end
    end
    ack_sel = 3'b001;
  endtask

  task automatic test_reset_mid_read();
    logic [2:0] ack; logic [31:0] rd; logic rp; int drv;
    logic o, t;
    ack_sel = 3'b001;
    send_req(mk_req(1'b0, 1'b1, 2'd2));
    for (int i = 0; i < 14; i++) swd_edge(1'b0, o, t);
    checks++;
    if (swd_if.SWDIO_T !== 1'b0) begin
      errors++; $display("FAIL midrd_driving: got T=%b want 0", swd_if.SWDIO_T);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({swd_if.SWDIO_T, locked_out} !== 2'b11) begin
      errors++; $display("FAIL midrd_reset: got T/lock=%b want 11", {swd_if.SWDIO_T, locked_out});
    end
    swd_if.SWCLK_I = 1'b0;
    swd_if.SWDIO_I = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dp_m[i] = '0;
      ap_m[i] = '0;
    end
    line_reset();
    swd_txn(mk_req(1'b0, 1'b1, 2'd2), 32'd0, 1'b0, ack, rd, rp, drv);
    checks++;
    if ({ack, rd} !== {3'b001, 32'd0}) begin
      errors++; $display("FAIL midrd_cleared: got ack=%b data=%h want 001 0", ack, rd);
    end
  endtask

  initial begin
    swd_if.SWCLK_I = 1'b0;
    swd_if.SWDIO_I = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dp_m[i] = '0;
      ap_m[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    resetn = 1'b1;
    test_linereset_idcode();
    test_write_read();
    test_wait();
    test_req_parity_err();
    test_wdata_parity_err();
    test_random(40);
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
